// File: rtl/alu_pkg.sv
// Shared definitions for alu_multiciclo: codop constants, FSM states and overflow helper.
// The serial multiplier (codop 13) exists only when ALU_MUL_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_GT   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ANDI = 4'd6;
    localparam logic [3:0] OP_ORI  = 4'd7;
    localparam logic [3:0] OP_XORI = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_SUBI = 4'd10;
    localparam logic [3:0] OP_MOV  = 4'd11;
    localparam logic [3:0] OP_MOVZ = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        MULT   = 1'b1
    } estado_t;

    // Two's-complement overflow of a +/- b from the operand and result sign bits.
    function automatic logic overflow_soma(input logic a_msb, input logic b_msb,
                                           input logic r_msb, input logic subtrai);
        logic b_efetivo;
        b_efetivo = b_msb ^ subtrai;
        return (a_msb == b_efetivo) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiplicador_serial.sv
// Shift-add unsigned multiplier: one partial product per cycle, 2*LARGURA-bit product.
// carga latches the operands and already performs the first step.
module multiplicador_serial #(
    parameter int unsigned LARGURA = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   carga,
    input  logic                   passo,
    input  logic [LARGURA-1:0]     multiplicando,
    input  logic [LARGURA-1:0]     multiplicador,
    output logic [2*LARGURA-1:0]   produto,
    output logic                   feito
);

    localparam int unsigned CW = $clog2(LARGURA + 1);

    logic [2*LARGURA-1:0] prod_q, prod_d;
    logic [LARGURA-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]        restantes_q, restantes_d;

    // Upper half accumulates (with carry), then the whole register shifts right by one.
    function automatic logic [2*LARGURA-1:0] desloca_soma(input logic [2*LARGURA-1:0] p,
                                                          input logic [LARGURA-1:0]   m);
        logic [LARGURA:0] soma;
        soma = {1'b0, p[2*LARGURA-1:LARGURA]} + (p[0] ? {1'b0, m} : {(LARGURA+1){1'b0}});
        return {soma, p[LARGURA-1:1]};
    endfunction

    always_comb begin
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        restantes_d = restantes_q;
        if (carga) begin
            mcand_d     = multiplicando;
            prod_d      = desloca_soma({{LARGURA{1'b0}}, multiplicador}, multiplicando);
            restantes_d = CW'(LARGURA - 1);
        end else if (passo && (restantes_q != '0)) begin
            prod_d      = desloca_soma(prod_q, mcand_q);
            restantes_d = restantes_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q      <= '0;
            mcand_q     <= '0;
            restantes_q <= '0;
        end else begin
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            restantes_q <= restantes_d;
        end
    end

    assign produto = prod_q;
    assign feito   = (restantes_q == '0);

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle ops complete in one cycle, MUL runs serially over LARGURA cycles.
// Define ALU_MUL_EN to build the serial multiplier; otherwise codop 13 is illegal.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int unsigned LARGURA = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inicio,
    input  logic [3:0]         codop,
    input  logic [LARGURA-1:0] operando1,
    input  logic [LARGURA-1:0] operando2,
    input  logic [LARGURA-1:0] imm,
    output logic [LARGURA-1:0] resultado,
    output logic               neg,
    output logic               zero,
    output logic               overflow,
    output logic               erro,
    output logic               pronto,
    output logic               ocupado
);

    localparam int unsigned MSB = LARGURA - 1;

    logic [LARGURA-1:0] resultado_q, resultado_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               erro_q, erro_d;
    logic               pronto_q, pronto_d;

    logic [LARGURA-1:0] ula_res;
    logic               ula_neg, ula_zero, ula_ovf, ula_erro;
    logic               conclui_ula;

`ifdef ALU_MUL_EN
    localparam int unsigned CW = $clog2(LARGURA + 1);

    estado_t              estado_q, estado_d;
    logic [CW-1:0]        cont_q, cont_d;
    logic                 ocupado_q, ocupado_d;
    logic                 mul_carga, mul_passo, mul_feito;
    logic [2*LARGURA-1:0] mul_produto;

    multiplicador_serial #(
        .LARGURA (LARGURA)
    ) u_mult (
        .clk           (clk),
        .reset         (reset),
        .carga         (mul_carga),
        .passo         (mul_passo),
        .multiplicando (operando1),
        .multiplicador (operando2),
        .produto       (mul_produto),
        .feito         (mul_feito)
    );
`endif

    // Single-cycle datapath; illegal codes and a not-taken MOVZ keep the old result.
    always_comb begin
        ula_res  = resultado_q;
        ula_neg  = 1'b0;
        ula_zero = 1'b0;
        ula_ovf  = 1'b0;
        ula_erro = 1'b0;
        case (codop)
            OP_ADD: begin
                ula_res = operando1 + operando2;
                ula_ovf = overflow_soma(operando1[MSB], operando2[MSB], ula_res[MSB], 1'b0);
            end
            OP_SUB: begin
                ula_res = operando1 - operando2;
                ula_ovf = overflow_soma(operando1[MSB], operando2[MSB], ula_res[MSB], 1'b1);
            end
            OP_GT:   ula_res = (operando1 > operando2) ? LARGURA'(1) : '0;
            OP_AND:  ula_res = operando1 & operando2;
            OP_OR:   ula_res = operando1 | operando2;
            OP_XOR:  ula_res = operando1 ^ operando2;
            OP_ANDI: ula_res = imm & operando2;
            OP_ORI:  ula_res = imm | operando2;
            OP_XORI: ula_res = imm ^ operando2;
            OP_ADDI: begin
                ula_res = imm + operando2;
                ula_ovf = overflow_soma(imm[MSB], operando2[MSB], ula_res[MSB], 1'b0);
            end
            OP_SUBI: begin
                ula_res = operando2 - imm;
                ula_ovf = overflow_soma(operando2[MSB], imm[MSB], ula_res[MSB], 1'b1);
            end
            OP_MOV:  ula_res = operando1;
            OP_MOVZ: begin
                if (operando1 == '0) begin
                    ula_res  = operando2;
                    ula_neg  = operando2[MSB];
                    ula_zero = 1'b1;
                end
            end
            default: ula_erro = 1'b1;
        endcase
        if (!ula_erro && (codop != OP_MOVZ)) begin
            ula_neg  = ula_res[MSB];
            ula_zero = (ula_res == '0);
        end
    end

    always_comb begin
        resultado_d = resultado_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        erro_d      = erro_q;
        pronto_d    = 1'b0;
        conclui_ula = 1'b0;
`ifdef ALU_MUL_EN
        estado_d  = estado_q;
        cont_d    = cont_q;
        ocupado_d = ocupado_q;
        mul_carga = 1'b0;
        mul_passo = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    if (codop == OP_MUL) begin
                        mul_carga = 1'b1;
                        estado_d  = MULT;
                        cont_d    = CW'(LARGURA);
                        ocupado_d = 1'b1;
                    end else begin
                        conclui_ula = 1'b1;
                    end
                end
            end
            MULT: begin
                mul_passo = 1'b1;
                cont_d    = cont_q - CW'(1);
                if ((cont_q == CW'(1)) && mul_feito) begin
                    resultado_d = mul_produto[LARGURA-1:0];
                    neg_d       = mul_produto[MSB];
                    zero_d      = (mul_produto[LARGURA-1:0] == '0);
                    overflow_d  = |mul_produto[2*LARGURA-1:LARGURA];
                    erro_d      = 1'b0;
                    pronto_d    = 1'b1;
                    ocupado_d   = 1'b0;
                    estado_d    = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
`else
        conclui_ula = inicio;
`endif
        if (conclui_ula) begin
            resultado_d = ula_res;
            neg_d       = ula_neg;
            zero_d      = ula_zero;
            overflow_d  = ula_ovf;
            erro_d      = ula_erro;
            pronto_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resultado_q <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            erro_q      <= 1'b0;
            pronto_q    <= 1'b0;
`ifdef ALU_MUL_EN
            estado_q    <= OCIOSO;
            cont_q      <= '0;
            ocupado_q   <= 1'b0;
`endif
        end else begin
            resultado_q <= resultado_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            erro_q      <= erro_d;
            pronto_q    <= pronto_d;
`ifdef ALU_MUL_EN
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            ocupado_q   <= ocupado_d;
`endif
        end
    end

    assign resultado = resultado_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign erro      = erro_q;
    assign pronto    = pronto_q;
`ifdef ALU_MUL_EN
    assign ocupado   = ocupado_q;
`else
    assign ocupado   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed cases plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_alu_multiciclo;

    localparam int unsigned W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         reset, inicio;
    logic [3:0]   codop;
    logic [W-1:0] operando1, operando2, imm;
    logic [W-1:0] resultado;
    logic         neg, zero, overflow, erro, pronto, ocupado;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] exp_res = '0;
    logic         exp_neg = 0, exp_zero = 0, exp_ovf = 0, exp_erro = 0;
    logic         exp_pronto = 0, exp_ocup = 0;
    int           mul_left = 0;
    logic [W-1:0] mul_res = '0;
    logic         mul_ovf = 0;

    alu_multiciclo #(
        .LARGURA (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inicio    (inicio),
        .codop     (codop),
        .operando1 (operando1),
        .operando2 (operando2),
        .imm       (imm),
        .resultado (resultado),
        .neg       (neg),
        .zero      (zero),
        .overflow  (overflow),
        .erro      (erro),
        .pronto    (pronto),
        .ocupado   (ocupado)
    );

    always #5 clk = ~clk;

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic fora(input longint s);
        return (s > MAXS) || (s < MINS);
    endfunction

    task automatic model_single(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] i);
        logic [W-1:0] r;
        logic         ov;
        ov = 1'b0;
        r  = exp_res;
        exp_pronto = 1'b1;
        if (c >= 13) begin
            exp_erro = 1'b1; exp_neg = 1'b0; exp_zero = 1'b0; exp_ovf = 1'b0;
            return;
        end
        if (c == 12) begin
            exp_erro = 1'b0; exp_ovf = 1'b0;
            if (a == 0) begin
                exp_res = b; exp_neg = b[W-1]; exp_zero = 1'b1;
            end else begin
                exp_neg = 1'b0; exp_zero = 1'b0;
            end
            return;
        end
        case (c)
            0:  begin r = W'(sx(a) + sx(b)); ov = fora(sx(a) + sx(b)); end
            1:  begin r = W'(sx(a) - sx(b)); ov = fora(sx(a) - sx(b)); end
            2:  r = (a > b) ? W'(1) : W'(0);
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = i & b;
            7:  r = i | b;
            8:  r = i ^ b;
            9:  begin r = W'(sx(i) + sx(b)); ov = fora(sx(i) + sx(b)); end
            10: begin r = W'(sx(b) - sx(i)); ov = fora(sx(b) - sx(i)); end
            default: r = a;
        endcase
        exp_res = r; exp_neg = r[W-1]; exp_zero = (r == 0); exp_ovf = ov; exp_erro = 1'b0;
    endtask

    always @(posedge clk) begin
        longint p;
        exp_pronto = 1'b0;
        if (reset) begin
            exp_res = '0; exp_neg = 0; exp_zero = 0; exp_ovf = 0; exp_erro = 0; exp_ocup = 0;
            mul_left = 0;
        end else if (mul_left != 0) begin
            mul_left = mul_left - 1;
            if (mul_left == 0) begin
                exp_res = mul_res; exp_neg = mul_res[W-1]; exp_zero = (mul_res == 0);
                exp_ovf = mul_ovf; exp_erro = 1'b0; exp_pronto = 1'b1; exp_ocup = 1'b0;
            end
        end else if (inicio) begin
            if (MUL_EN && (codop == 4'd13)) begin
                p        = longint'(operando1) * longint'(operando2);
                mul_res  = W'(p);
                mul_ovf  = ((p >> W) != 0);
                mul_left = W;
                exp_ocup = 1'b1;
            end else begin
                model_single(codop, operando1, operando2, imm);
            end
        end
    end

    task automatic chk(input string nome, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nome, act, req, $time);
        end
    endtask

    task automatic cmp_all();
        chk("resultado", resultado, exp_res);
        chk("neg", W'(neg), W'(exp_neg));
        chk("zero", W'(zero), W'(exp_zero));
        chk("overflow", W'(overflow), W'(exp_ovf));
        chk("erro", W'(erro), W'(exp_erro));
        chk("pronto", W'(pronto), W'(exp_pronto));
        chk("ocupado", W'(ocupado), W'(exp_ocup));
    endtask

    // Compare against the model mid-cycle, then advance to just after the next edge.
    task automatic tick();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] i);
        codop = c; operando1 = a; operando2 = b; imm = i; inicio = 1'b1;
        tick();
        inicio = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inicio = 1'b0; codop = '0; operando1 = '0; operando2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst resultado", resultado, 16'h0000);
        chk("rst pronto", W'(pronto), 16'h0);
        chk("rst ocupado", W'(ocupado), 16'h0);
        chk("rst erro", W'(erro), 16'h0);

        issue(4'd0, 16'h7FFF, 16'h0001, 16'h0000);
        chk("add res", resultado, 16'h8000);
        chk("add neg", W'(neg), 16'h1);
        chk("add ovf", W'(overflow), 16'h1);
        chk("add zero", W'(zero), 16'h0);
        chk("add pronto", W'(pronto), 16'h1);
        tick();
        chk("add pronto drop", W'(pronto), 16'h0);
        chk("add hold", resultado, 16'h8000);

        issue(4'd10, 16'h1111, 16'h0005, 16'h0005);
        chk("subi res", resultado, 16'h0000);
        chk("subi zero", W'(zero), 16'h1);
        chk("subi ovf", W'(overflow), 16'h0);
        issue(4'd5, 16'h00FF, 16'h0F0F, 16'h0000);
        chk("xor b2b res", resultado, 16'h0FF0);
        chk("xor b2b pronto", W'(pronto), 16'h1);

        issue(4'd2, 16'h8000, 16'h7FFF, 16'h0000);
        chk("gt unsigned", resultado, 16'h0001);

        issue(4'd12, 16'h0000, 16'h1234, 16'h0000);
        chk("movz taken res", resultado, 16'h1234);
        chk("movz taken zero", W'(zero), 16'h1);
        issue(4'd12, 16'h0003, 16'h5555, 16'h0000);
        chk("movz hold res", resultado, 16'h1234);
        chk("movz hold zero", W'(zero), 16'h0);

        issue(4'd15, 16'h0001, 16'h0002, 16'h0003);
        chk("illegal res", resultado, 16'h1234);
        chk("illegal erro", W'(erro), 16'h1);
        chk("illegal pronto", W'(pronto), 16'h1);
`ifndef ALU_MUL_EN
        issue(4'd0, 16'h0001, 16'h0001, 16'h0000);
        issue(4'd13, 16'h0003, 16'h0004, 16'h0000);
        chk("op13 res", resultado, 16'h0002);
        chk("op13 erro", W'(erro), 16'h1);
        chk("op13 pronto", W'(pronto), 16'h1);
        chk("op13 ocupado", W'(ocupado), 16'h0);
`endif

        // Reset and request together: the request is lost.
        codop = 4'd0; operando1 = 16'h0001; operando2 = 16'h0001; inicio = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; inicio = 1'b0;
        chk("rst+inicio pronto", W'(pronto), 16'h0);
        chk("rst+inicio res", resultado, 16'h0000);

`ifdef ALU_MUL_EN
        issue(4'd13, 16'd300, 16'd200, 16'h0000);
        for (int c = 1; c <= int'(W); c++) begin
            chk("mul ocupado", W'(ocupado), 16'h1);
            chk("mul pronto early", W'(pronto), 16'h0);
            if (c == 5) begin
                codop = 4'd0; operando1 = 16'h0101; operando2 = 16'h0101; inicio = 1'b1;
            end
            tick();
            inicio = 1'b0;
        end
        chk("mul res", resultado, 16'hEA60);
        chk("mul ovf", W'(overflow), 16'h0);
        chk("mul pronto", W'(pronto), 16'h1);
        chk("mul ocupado end", W'(ocupado), 16'h0);

        issue(4'd13, 16'h0100, 16'h0100, 16'h0000);
        repeat (W) tick();
        chk("mul hi res", resultado, 16'h0000);
        chk("mul hi zero", W'(zero), 16'h1);
        chk("mul hi ovf", W'(overflow), 16'h1);

        issue(4'd13, 16'h0007, 16'h0009, 16'h0000);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort res", resultado, 16'h0000);
        chk("abort ocupado", W'(ocupado), 16'h0);
        chk("abort zero", W'(zero), 16'h0);
        for (int c = 0; c < int'(W); c++) begin
            chk("abort no pronto", W'(pronto), 16'h0);
            tick();
        end
        issue(4'd15, 16'h0001, 16'h0002, 16'h0003);
        chk("abort illegal res", resultado, 16'h0000);
        chk("abort illegal erro", W'(erro), 16'h1);
        chk("abort illegal pronto", W'(pronto), 16'h1);
`endif

        for (int n = 0; n < 2500; n++) begin
            logic [W-1:0] esp [6];
            esp[0] = 16'h0000; esp[1] = 16'hFFFF; esp[2] = 16'h7FFF;
            esp[3] = 16'h8000; esp[4] = 16'h0001; esp[5] = 16'h0100;
            reset  = ($urandom_range(0, 149) == 0);
            inicio = $urandom_range(0, 1);
            codop  = 4'($urandom_range(0, 15));
            operando1 = ($urandom_range(0, 3) == 0) ? esp[$urandom_range(0, 5)] : W'($urandom);
            operando2 = ($urandom_range(0, 3) == 0) ? esp[$urandom_range(0, 5)] : W'($urandom);
            imm       = ($urandom_range(0, 3) == 0) ? esp[$urandom_range(0, 5)] : W'($urandom);
            if ($urandom_range(0, 7) == 0) operando1 = '0;
            tick();
        end
        reset = 1'b0; inicio = 1'b0;
        repeat (W + 2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, multi-cycle successor to the processor's 16-bit ALU. Accepts one operation per `inicio` pulse and returns a registered result, flags and a one-cycle `pronto` strobe. Single-cycle operations complete in 1 cycle; the added unsigned multiply runs serially over `LARGURA` cycles. Sits in the execute stage between operand fetch and write-back; the control unit stalls on `ocupado`.

## Interface
- `LARGURA`, 16: datapath width in bits; must be ≥ 4.
- `clk  in  1`: single clock; all logic changes on the rising edge.
- `reset  in  1`: synchronous, active-high; sampled on the `clk` rising edge.
- `inicio  in  1`: operation request; accepted only when `ocupado`=0.
- `codop  in  4`: operation code, sampled at accept.
- `operando1  in  LARGURA`: operand A, sampled at accept.
- `operando2  in  LARGURA`: operand B, sampled at accept.
- `imm  in  LARGURA`: immediate, already sign-extended by the decoder; sampled at accept.
- `resultado  out  LARGURA`: result register; holds its value between operations.
- `neg  out  1`: result MSB.
- `zero  out  1`: result-zero flag, or the condition flag for MOVZ.
- `overflow  out  1`: signed overflow for add/sub; high-half-nonzero for MUL.
- `erro  out  1`: illegal codop on the last completed operation.
- `pronto  out  1`: one-cycle strobe; result and flags valid.
- `ocupado  out  1`: multiply in progress; new requests are ignored.

## Operation
- codop 0 ADD: op1+op2.
- codop 1 SUB: op1−op2.
- codop 2 GT: 1 if op1>op2 (unsigned), else 0.
- codop 3/4/5 AND/OR/XOR: op1 with op2.
- codop 6/7/8 ANDI/ORI/XORI: imm with op2.
- codop 9 ADDI: imm+op2.
- codop 10 SUBI: op2−imm.
- codop 11 MOV: op1.
- codop 12 MOVZ: if op1==0, resultado=op2 and zero=1; otherwise resultado is unchanged and zero=0.
- codop 13 MUL: unsigned op1×op2, low `LARGURA` bits. Present only with `ALU_MUL_EN`.
- codop 14, 15 (and 13 without the macro): illegal. resultado is unchanged, erro=1, neg=zero=overflow=0, and `pronto` still pulses.
- Flags on every legal completion:
  - erro=0.
  - neg=resultado[MSB] (except MOVZ not-taken, where neg=0).
  - zero=(resultado==0) (except MOVZ, as above).
  - overflow: ADD/SUB/ADDI/SUBI use the two's-complement sign rule; MUL sets it when the discarded high half is nonzero; all other ops give 0.
- All arithmetic wraps modulo 2^LARGURA.
- FSM states:
  - OCIOSO: `inicio`=1 with codop≠13 completes immediately, stays in OCIOSO. `inicio`=1 with codop 13 loads the multiplier and moves to MULT.
  - MULT: shift-add counter runs from `LARGURA` down to 1. At count 1, writes the result and flags, pulses `pronto`, and returns to OCIOSO.
- Reset values: resultado=0, neg=zero=overflow=erro=pronto=ocupado=0, state OCIOSO, counter 0.

## Timing
- Let T be the accept edge (`inicio`=1, `ocupado`=0).
- Non-MUL operations: outputs and `pronto`=1 are valid in cycle T+1. `pronto` lasts exactly one cycle.
- MUL:
  - `ocupado`=1 in cycles T+1 … T+`LARGURA`.
  - `pronto`=1 and the result appear in cycle T+`LARGURA`+1, with `ocupado`=0.
  - Latency is `LARGURA`+1 cycles.
- `inicio` while `ocupado`=1 is dropped, not queued.
- `inicio` in the same cycle as `pronto` (with `ocupado`=0) is accepted. Back-to-back single-cycle ops give one result per cycle.
- Operand changes after accept have no effect.
- Reset asserted mid-MUL: the operation aborts, no `pronto` is produced, and all outputs take their reset values in the next cycle.
- Reset and `inicio` asserted together: reset wins and the request is discarded.

## Configuration
- `ALU_MUL_EN` defined:
  - Serial multiplier instantiated.
  - MULT state exists.
  - codop 13 is legal.
- `ALU_MUL_EN` undefined:
  - No multiplier logic is instantiated.
  - `ocupado` is tied to 0.
  - codop 13 is treated as illegal (erro=1, 1-cycle `pronto`).
  - All other behaviour is identical.

## Structure
- Package `alu_pkg`:
  - codop constants: OP_ADD … OP_MOVZ = 0…12, OP_MUL = 13.
  - FSM state encoding: OCIOSO, MULT.
  - Overflow helper function.
- Sub-module `multiplicador_serial`, parameterised by `LARGURA`:
  - load/step inputs.
  - 2·`LARGURA` product register and done output.
- Top level contains the opcode decode, flag logic, FSM and output registers.

## Test plan
- ADD 0x7FFF+0x0001 → resultado 0x8000, neg=1, overflow=1, zero=0, `pronto` in T+1 only.
- SUBI with op2=5, imm=5 → resultado 0x0000, zero=1, neg=0, overflow=0. Then a back-to-back XOR 0x00FF^0x0F0F next cycle → 0x0FF0, one cycle later.
- MUL 300×200 (LARGURA=16) → 0xEA60, overflow=0. `ocupado` is high exactly 16 cycles and `pronto` comes 17 cycles after accept. An ADD request at cycle T+5 is ignored.
- MUL 0x0100×0x0100 → resultado 0x0000, zero=1, overflow=1.
- MOVZ with op1=0, op2=0x1234 → 0x1234, zero=1. Then MOVZ with op1=3 → resultado stays 0x1234, zero=0.
- Reset at T+5 of a MUL → no `pronto`, all outputs 0 in the next cycle. Then codop 15 → erro=1, `pronto`=1, resultado unchanged (0). Without `ALU_MUL_EN`, codop 13 behaves the same as codop 15.
